// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter: round-robin arbiter for the single object_grid write
// port. Accepts one player write every two cycles, rejects out-of-range
// cells with a nak, and freezes all writes for FREEZE_CYCLES after each
// vsync rising edge so the graphics path reads a stable grid snapshot.
module grid_access_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ROWS          = 8,
  parameter int COLS          = 13,
  parameter int OBJ_W         = 4,
  parameter int FREEZE_CYCLES = 16,
  localparam int ROW_W        = $clog2(ROWS),
  localparam int COL_W        = $clog2(COLS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ROW_W-1:0] req_row,
  input  logic [NUM_REQ*COL_W-1:0] req_col,
  input  logic [NUM_REQ*OBJ_W-1:0] req_obj,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       nak,
  output logic                     wr_en,
  output logic [ROW_W-1:0]         wr_row,
  output logic [COL_W-1:0]         wr_col,
  output logic [OBJ_W-1:0]         wr_obj,
  output logic [1:0]               grant_id,
  output logic                     frozen
);

  localparam int CNT_W = $clog2(FREEZE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FREEZE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK, FREEZE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [1:0]         rr_ptr, rr_d, gid_d;
  logic               vsync_q, vs_rise;
  logic [NUM_REQ-1:0] gnt_d, nak_d;
  logic               wr_en_d;
  logic [ROW_W-1:0]   row_d, sel_row;
  logic [COL_W-1:0]   col_d, sel_col;
  logic [OBJ_W-1:0]   obj_d, sel_obj;
  logic               found, in_range;
  logic [1:0]         sel, cand;

  assign vs_rise = vsync & ~vsync_q;
  assign frozen  = (state == FREEZE);

  // Round-robin pick: first active request after the last winner.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_row  = req_row[int'(sel)*ROW_W +: ROW_W];
  assign sel_col  = req_col[int'(sel)*COL_W +: COL_W];
  assign sel_obj  = req_obj[int'(sel)*OBJ_W +: OBJ_W];
  assign in_range = (int'(sel_row) < ROWS) && (int'(sel_col) < COLS);

  // Next-state and next-output logic; pulses default low, write fields hold.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rr_d    = rr_ptr;
    gid_d   = grant_id;
    gnt_d   = '0;
    nak_d   = '0;
    wr_en_d = 1'b0;
    row_d   = wr_row;
    col_d   = wr_col;
    obj_d   = wr_obj;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_d = FREEZE;
          cnt_d   = CNT_LOAD;
        end else if (found) begin
          state_d = ACK;
          rr_d    = sel;
          gid_d   = sel;
          if (in_range) begin
            gnt_d   = NUM_REQ'(1) << sel;
            wr_en_d = 1'b1;
            row_d   = sel_row;
            col_d   = sel_col;
            obj_d   = sel_obj;
          end else begin
            nak_d = NUM_REQ'(1) << sel;
          end
        end
      end
      // The winner's req is still high here; no selection masks it.
      ACK: begin
        if (vs_rise) begin
          state_d = FREEZE;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      FREEZE: begin
        if (vs_rise) begin
          cnt_d = CNT_LOAD;
        end else if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; vsync_q resets high to avoid a false edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= 2'(NUM_REQ - 1);
      grant_id <= '0;
      vsync_q  <= 1'b1;
      gnt      <= '0;
      nak      <= '0;
      wr_en    <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_obj   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rr_ptr   <= rr_d;
      grant_id <= gid_d;
      vsync_q  <= vsync;
      gnt      <= gnt_d;
      nak      <= nak_d;
      wr_en    <= wr_en_d;
      wr_row   <= row_d;
      wr_col   <= col_d;
      wr_obj   <= obj_d;
    end
  end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_grid_access_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        vsync;
  logic [3:0]  req;
  logic [11:0] req_row;
  logic [15:0] req_col;
  logic [15:0] req_obj;
  logic [3:0]  gnt, nak;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [3:0]  wr_col;
  logic [3:0]  wr_obj;
  logic [1:0]  grant_id;
  logic        frozen;

  int checks = 0;
  int failures = 0;

  grid_access_arbiter dut (
    .clock(clock), .reset(reset), .vsync(vsync), .req(req),
    .req_row(req_row), .req_col(req_col), .req_obj(req_obj),
    .gnt(gnt), .nak(nak), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_obj(wr_obj), .grant_id(grant_id), .frozen(frozen)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [2:0] r,
                         input logic [3:0] c, input logic [3:0] o);
    req_row[i*3 +: 3] = r;
    req_col[i*4 +: 4] = c;
    req_obj[i*4 +: 4] = o;
  endtask

  // Reset with quiet inputs, then three idle cycles so vsync_q settles low.
  task automatic do_reset();
    tick();
    reset = 1'b1; vsync = 1'b0; req = '0;
    req_row = '0; req_col = '0; req_obj = '0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1; vsync = 1'b0; req = '0;
    req_row = '0; req_col = '0; req_obj = '0;
    tick();
    checks++;
    if ({gnt, nak, wr_en, wr_row, wr_col, wr_obj, grant_id, frozen} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b nak=%b wr_en=%b row=%0d col=%0d obj=%0d id=%0d frozen=%b, want all 0",
               gnt, nak, wr_en, wr_row, wr_col, wr_obj, grant_id, frozen);
    end
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_single_write();
    set_req(0, 3'd2, 4'd5, 4'd3);
    req = 4'b0001;
    tick();
    checks++;
    if ({gnt, wr_en, wr_row, wr_col, wr_obj} !== {4'b0001, 1'b1, 3'd2, 4'd5, 4'd3}) begin
      failures++;
      $display("FAIL single_write: got gnt=%b wr_en=%b row=%0d col=%0d obj=%0d, want 0001 1 2 5 3",
               gnt, wr_en, wr_row, wr_col, wr_obj);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, nak, wr_en} !== 9'd0) begin
      failures++;
      $display("FAIL single_write_clear: got gnt=%b nak=%b wr_en=%b, want 0", gnt, nak, wr_en);
    end
  endtask

  task automatic test_round_robin();
    int order[4];
    int when[4];
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 4'(i + 8), 4'(i + 10));
    req = 4'b1111;
    for (int cyc = 1; cyc <= 12 && n < 4; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          order[n] = i; when[n] = cyc; n++;
          checks++;
          if ({wr_en, wr_row, wr_col, wr_obj} !== {1'b1, 3'(i + 1), 4'(i + 8), 4'(i + 10)}) begin
            failures++;
            $display("FAIL rr_fields%0d: got wr_en=%b row=%0d col=%0d obj=%0d, want 1 %0d %0d %0d",
                     i, wr_en, wr_row, wr_col, wr_obj, i + 1, i + 8, i + 10);
          end
          req[i] = 1'b0;
        end
      end
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL rr_count: got %0d grants, want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (order[k] !== k || when[k] !== 2 * k + 1) begin
          failures++;
          $display("FAIL rr_order%0d: got id=%0d cycle=%0d, want id=%0d cycle=%0d",
                   k, order[k], when[k], k, 2 * k + 1);
        end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_nak();
    do_reset();
    set_req(1, 3'd7, 4'd13, 4'd6);
    set_req(2, 3'd4, 4'd12, 4'd9);
    req = 4'b0110;
    tick();
    checks++;
    if ({nak, gnt, wr_en, grant_id, wr_row, wr_col, wr_obj} !== {4'b0010, 4'b0000, 1'b0, 2'd1, 3'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL nak_pulse: got nak=%b gnt=%b wr_en=%b id=%0d row=%0d col=%0d obj=%0d, want 0010 0000 0 1 0 0 0",
               nak, gnt, wr_en, grant_id, wr_row, wr_col, wr_obj);
    end
    req[1] = 1'b0;
    tick();
    checks++;
    if ({nak, gnt, wr_en} !== 9'd0) begin
      failures++;
      $display("FAIL nak_clear: got nak=%b gnt=%b wr_en=%b, want 0", nak, gnt, wr_en);
    end
    tick();
    checks++;
    if ({gnt, nak, wr_en, grant_id, wr_row, wr_col, wr_obj} !== {4'b0100, 4'b0000, 1'b1, 2'd2, 3'd4, 4'd12, 4'd9}) begin
      failures++;
      $display("FAIL nak_other: got gnt=%b nak=%b wr_en=%b id=%0d row=%0d col=%0d obj=%0d, want 0100 0000 1 2 4 12 9",
               gnt, nak, wr_en, grant_id, wr_row, wr_col, wr_obj);
    end
    req = '0;
    tick();
  endtask

  // Counts frozen cycles (bounded) and flags any grant seen while frozen.
  task automatic count_freeze(input string tag, input int expect_len);
    int len = 0;
    int bad = 0;
    for (int cyc = 0; cyc < 40 && frozen === 1'b1; cyc++) begin
      len++;
      if (gnt !== 4'b0000 || wr_en !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (len !== expect_len || bad !== 0) begin
      failures++;
      $display("FAIL %s_freeze: got %0d frozen cycles with %0d grants, want %0d with 0",
               tag, len, bad, expect_len);
    end
  endtask

  task automatic test_vsync_idle();
    do_reset();
    set_req(0, 3'd1, 4'd1, 4'd1);
    req = 4'b0001;
    vsync = 1'b1;
    tick();
    checks++;
    if (frozen !== 1'b1 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL vs_idle_enter: got frozen=%b gnt=%b, want 1 0000", frozen, gnt);
    end
    count_freeze("vs_idle", 16);
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL vs_idle_exit: got gnt=%b, want 0000", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL vs_idle_grant: got gnt=%b wr_en=%b, want 0001 1", gnt, wr_en);
    end
    req = '0; vsync = 1'b0;
    tick();
  endtask

  task automatic test_vsync_ack();
    do_reset();
    set_req(0, 3'd6, 4'd2, 4'd15);
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || wr_en !== 1'b1 || frozen !== 1'b0) begin
      failures++;
      $display("FAIL vs_ack_grant: got gnt=%b wr_en=%b frozen=%b, want 0001 1 0", gnt, wr_en, frozen);
    end
    vsync = 1'b1;
    req = '0;
    tick();
    count_freeze("vs_ack", 16);
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_freeze();
    do_reset();
    set_req(2, 3'd3, 4'd7, 4'd5);
    req = 4'b0100;
    vsync = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (frozen !== 1'b1) begin
      failures++;
      $display("FAIL rif_frozen: got frozen=%b, want 1", frozen);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, nak, wr_en, wr_row, wr_col, wr_obj, grant_id, frozen} !== 25'd0) begin
      failures++;
      $display("FAIL rif_clear: got gnt=%b nak=%b wr_en=%b row=%0d col=%0d obj=%0d id=%0d frozen=%b, want all 0",
               gnt, nak, wr_en, wr_row, wr_col, wr_obj, grant_id, frozen);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0100 || wr_en !== 1'b1 || frozen !== 1'b0 ||
        {wr_row, wr_col, wr_obj} !== {3'd3, 4'd7, 4'd5}) begin
      failures++;
      $display("FAIL rif_regrant: got gnt=%b wr_en=%b frozen=%b row=%0d col=%0d obj=%0d, want 0100 1 0 3 7 5",
               gnt, wr_en, frozen, wr_row, wr_col, wr_obj);
    end
    req = '0; vsync = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; req = '0;
    req_row = '0; req_col = '0; req_obj = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_nak();
    test_vsync_idle();
    test_vsync_ack();
    test_reset_in_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
